// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer controller and datapath.
// The state encoding doubles as the 2-bit datapath command.
package reaction_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DELAY   = 2'd1,
        S_TIMING  = 2'd2,
        S_DISPLAY = 2'd3
    } state_e;

    // Default millisecond constants (1 kHz clock, 1 cycle = 1 ms)
    localparam int TIMEOUT_MS_DEF  = 999;
    localparam int HOLD_MS_DEF     = 500;
    localparam int DEBOUNCE_MS_DEF = 20;
    localparam int SYNC_STAGES_DEF = 2;

    // Button lanes
    localparam int NUM_KEYS  = 2;
    localparam int KEY_START = 0;
    localparam int KEY_STOP  = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Key / datapath bundle between the reaction controller and its environment.
// master drives the raw keys and the datapath flag; slave is the controller.
interface reaction_ctrl_if;

    logic       StartN;
    logic       StopN;
    logic       Flag;
    logic [1:0] state;
    logic       Timeout;
    logic       FalseStart;
    logic       Busy;

    modport master (
        output StartN, StopN, Flag,
        input  state, Timeout, FalseStart, Busy
    );

    modport slave (
        input  StartN, StopN, Flag,
        output state, Timeout, FalseStart, Busy
    );

endinterface

// File: rtl/reaction_ctrl_btn_cond.sv
// Pushbutton conditioner: synchronizer, rising-edge detect, debounce lockout.
// press is registered, so pin-to-press latency is SYNC_STAGES+1 cycles.
module btn_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int LW = $clog2(DEBOUNCE_MS + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [LW-1:0]          lock;
    logic                   rise;
    logic                   accept;

    assign rise   = sync[SYNC_STAGES-1] & ~prev;
    assign accept = rise && (lock == '0);

    // Synchronize the inverted key and register the accepted edge as a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            prev  <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], ~key_n};
            prev  <= sync[SYNC_STAGES-1];
            press <= accept;
        end
    end

    // Lockout window: edges are ignored for DEBOUNCE_MS cycles after a press
    always_ff @(posedge clk) begin
        if (rst)
            lock <= '0;
        else if (accept)
            lock <= LW'(DEBOUNCE_MS);
        else if (lock != '0)
            lock <= lock - LW'(1);
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencing controller: IDLE -> DELAY -> TIMING -> DISPLAY.
// Optional feature macro: REACTION_FALSE_START_EN (Stop during DELAY aborts
// the run and raises FalseStart; when undefined Stop is ignored in DELAY).
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TIMEOUT_MS  = TIMEOUT_MS_DEF,
    parameter int HOLD_MS     = HOLD_MS_DEF,
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic           Clock,
    input  logic           Reset,
    reaction_ctrl_if.slave bus
);

    localparam int CW = $clog2(max2(TIMEOUT_MS, HOLD_MS) + 1);

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] press;
    logic                start_press;
    logic                stop_press;

    state_e        state_q, state_d;
    logic [CW-1:0] elapsed_q, elapsed_d, elapsed_inc;
    logic [CW-1:0] hold_q, hold_d, hold_inc;
    logic          to_q, to_d;
    logic          fs_q, fs_d;
    logic          busy_q;

    assign key_n       = {bus.StopN, bus.StartN};
    assign start_press = press[KEY_START];
    assign stop_press  = press[KEY_STOP];

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        btn_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_MS (DEBOUNCE_MS)
        ) u_btn (
            .clk   (Clock),
            .rst   (Reset),
            .key_n (key_n[k]),
            .press (press[k])
        );
    end

    // Saturating increments; the incremented value equals the number of
    // cycles spent in the state including the current one, so TIMING lasts
    // exactly TIMEOUT_MS cycles and DISPLAY at least HOLD_MS cycles.
    assign elapsed_inc = (elapsed_q == '1) ? elapsed_q : elapsed_q + CW'(1);
    assign hold_inc    = (hold_q == '1)    ? hold_q    : hold_q + CW'(1);

    // Next-state, counter and flag logic
    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        fs_d      = fs_q;
        elapsed_d = (state_q == S_TIMING)  ? elapsed_inc : elapsed_q;
        hold_d    = (state_q == S_DISPLAY) ? hold_inc    : hold_q;

        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    state_d = S_DELAY;
                    to_d    = 1'b0;
                    fs_d    = 1'b0;
                end
            end
            S_DELAY: begin
                // Flag has priority; a coincident Stop pulse is simply dropped
                if (bus.Flag) begin
                    state_d = S_TIMING;
                end
`ifdef REACTION_FALSE_START_EN
                else if (stop_press) begin
                    state_d = S_IDLE;
                    fs_d    = 1'b1;
                end
`else
                // Stop is ignored here; only Flag leaves DELAY
`endif
            end
            S_TIMING: begin
                if (stop_press) begin
                    state_d = S_DISPLAY;
                end else if (elapsed_inc >= CW'(TIMEOUT_MS)) begin
                    state_d = S_DISPLAY;
                    to_d    = 1'b1;
                end
            end
            S_DISPLAY: begin
                // Early Start presses fall through and are lost
                if (start_press && (hold_inc >= CW'(HOLD_MS)))
                    state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_TIMING) && (state_q != S_TIMING))
            elapsed_d = '0;
        if ((state_d == S_DISPLAY) && (state_q != S_DISPLAY))
            hold_d = '0;
    end

    // State, counters and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            elapsed_q <= '0;
            hold_q    <= '0;
            to_q      <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elapsed_q <= elapsed_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            fs_q      <= fs_d;
            busy_q    <= (state_d == S_DELAY) || (state_d == S_TIMING);
        end
    end

    assign bus.state      = state_q;
    assign bus.Timeout    = to_q;
    assign bus.FalseStart = fs_q;
    assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: directed vector table, hand-written
// timing sequences, and randomized key/flag traffic against a reference model.
module tb_reaction_ctrl;

    localparam int TIMEOUT_MS  = 999;
    localparam int HOLD_MS     = 500;
    localparam int DEBOUNCE_MS = 20;
    localparam int SYNC_STAGES = 2;
    localparam int MAXT        = 50000;
`ifdef REACTION_FALSE_START_EN
    localparam bit FS_EN = 1'b1;
`else
    localparam bit FS_EN = 1'b0;
`endif

    logic Clock;
    logic Reset;
    reaction_ctrl_if bus();

    reaction_ctrl #(
        .TIMEOUT_MS  (TIMEOUT_MS),
        .HOLD_MS     (HOLD_MS),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int nvec = 0;
    int nerr = 0;

    // ---------------- reference model ----------------
    // Keys: pressed level sampled each edge; a press is the first pressed
    // sample after a released one, seen by the FSM SYNC_STAGES+1 edges later,
    // unless within DEBOUNCE_MS cycles of the previous accepted press.
    bit prs [2][MAXT];
    int t        = 0;
    int last_rst = 0;
    int entry    = 0;
    int last_acc [2];
    bit m_press  [2];
    int ms       = 0;
    bit m_to     = 1'b0;
    bit m_fs     = 1'b0;

    task automatic model_step();
        int k, nxt, e;
        bit sp, tp;
        bit now_p [2];
        t++;
        now_p[0] = !bus.StartN;
        now_p[1] = !bus.StopN;
        if (Reset) begin
            ms = 0; m_to = 1'b0; m_fs = 1'b0; entry = t; last_rst = t;
            for (int j = 0; j < 2; j++) begin
                prs[j][t] = 1'b0; m_press[j] = 1'b0; last_acc[j] = -1000;
            end
            return;
        end
        sp  = m_press[0];
        tp  = m_press[1];
        k   = t - entry;
        nxt = ms;
        case (ms)
            0: if (sp) begin nxt = 1; m_to = 1'b0; m_fs = 1'b0; end
            1: if (bus.Flag) nxt = 2;
               else if (FS_EN && tp) begin nxt = 0; m_fs = 1'b1; end
            2: if (tp) nxt = 3;
               else if (k >= TIMEOUT_MS) begin nxt = 3; m_to = 1'b1; end
            default: if (sp && k >= HOLD_MS) nxt = 0;
        endcase
        if (nxt != ms) begin ms = nxt; entry = t; end
        for (int j = 0; j < 2; j++) begin
            prs[j][t]  = now_p[j];
            e          = t - SYNC_STAGES;
            m_press[j] = 1'b0;
            if (e > last_rst && prs[j][e] && !prs[j][e-1] && (t - last_acc[j]) > DEBOUNCE_MS) begin
                m_press[j]  = 1'b1;
                last_acc[j] = t;
            end
        end
    endtask

    function automatic logic [4:0] model_exp();
        return {ms[1:0], (ms == 1 || ms == 2), m_to, m_fs};
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [4:0] ex(input int st, input bit to, input bit fs);
        logic [1:0] s;
        s = st[1:0];
        return {s, (st == 1 || st == 2), to, fs};
    endfunction

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.state, bus.Busy, bus.Timeout, bus.FalseStart};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got state=%0d busy=%0b to=%0b fs=%0b, want state=%0d busy=%0b to=%0b fs=%0b",
                     nm, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset(input string nm);
        Reset = 1'b1; bus.StartN = 1'b1; bus.StopN = 1'b1; bus.Flag = 1'b0;
        tick();
        Reset = 1'b0;
        check(nm, ex(0, 0, 0));
    endtask

    // Pulse a key low for one sample, then wait until its press is registered
    task automatic press_key(input int k);
        if (k == 0) bus.StartN = 1'b0; else bus.StopN = 1'b0;
        tick();
        bus.StartN = 1'b1; bus.StopN = 1'b1;
        tick(); tick();
    endtask

    // Count consecutive TIMING samples (current one included), bounded
    task automatic count_timing(input int stop_at, output int n);
        n = (bus.state == 2'd2) ? 1 : 0;
        for (int i = 1; i < 2000; i++) begin
            bus.StopN = (i == stop_at) ? 1'b0 : 1'b1;
            tick();
            if (bus.state == 2'd2) n++;
            else break;
        end
        bus.StopN = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        bit         start_n;
        bit         stop_n;
        bit         flag;
        int         cyc;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input bit sn, input bit tn, input bit fl,
                       input int cyc, input int st, input bit to, input bit fs);
        vec_t v;
        v.name = nm; v.start_n = sn; v.stop_n = tn; v.flag = fl; v.cyc = cyc;
        v.exp  = ex(st, to, fs);
        tbl.push_back(v);
    endtask

    initial begin
        int n2;
        int lo_left [2];
        int rate [2];
        rate[0] = 79; rate[1] = 499;
        lo_left[0] = 0; lo_left[1] = 0;
        for (int j = 0; j < 2; j++) last_acc[j] = -1000;

        // name           StartN StopN Flag cyc  state to fs
        add("idle",        1, 1, 0,   1, 0, 0, 0);
        add("start_lo",    0, 1, 0,   1, 0, 0, 0);
        add("start_sync",  1, 1, 0,   2, 0, 0, 0);
        add("start_delay", 1, 1, 0,   1, 1, 0, 0);
        add("delay_wait",  1, 1, 0,  10, 1, 0, 0);
        add("flag",        1, 1, 1,   1, 2, 0, 0);
        add("timing",      1, 1, 0,   5, 2, 0, 0);
        add("stop_lo",     1, 0, 0,   1, 2, 0, 0);
        add("stop_sync",   1, 1, 0,   2, 2, 0, 0);
        add("stop_disp",   1, 1, 0,   1, 3, 0, 0);
        add("early_lo",    0, 1, 0,   1, 3, 0, 0);
        add("early_wait",  1, 1, 0,  30, 3, 0, 0);
        add("hold_wait",   1, 1, 0, 480, 3, 0, 0);
        add("go_lo",       0, 1, 0,   1, 3, 0, 0);
        add("go_sync",     1, 1, 0,   2, 3, 0, 0);
        add("go_idle",     1, 1, 0,   1, 0, 0, 0);
        add("idle_wait",   1, 1, 0,  30, 0, 0, 0);
        add("rerun_lo",    0, 1, 0,   1, 0, 0, 0);
        add("rerun_sync",  1, 1, 0,   2, 0, 0, 0);
        add("rerun",       1, 1, 0,   1, 1, 0, 0);
        add("flag2",       1, 1, 1,   1, 2, 0, 0);
        add("to_wait",     1, 1, 0, 998, 2, 0, 0);
        add("timeout",     1, 1, 0,   1, 3, 1, 0);
        add("disp_wait",   1, 1, 0, 600, 3, 1, 0);
        add("go2_lo",      0, 1, 0,   1, 3, 1, 0);
        add("go2_sync",    1, 1, 0,   2, 3, 1, 0);
        add("go2_idle",    1, 1, 0,   1, 0, 1, 0);
        add("idle_wait2",  1, 1, 0,  30, 0, 1, 0);
        add("run3_lo",     0, 1, 0,   1, 0, 1, 0);
        add("run3_sync",   1, 1, 0,   2, 0, 1, 0);
        add("run3",        1, 1, 0,   1, 1, 0, 0);
        add("fs_lo",       1, 0, 0,   1, 1, 0, 0);
        add("fs_sync",     1, 1, 0,   2, 1, 0, 0);
`ifdef REACTION_FALSE_START_EN
        add("fs_evt",      1, 1, 0,   1, 0, 0, 1);
        add("fs_hold",     1, 1, 0,  30, 0, 0, 1);
        add("run4_lo",     0, 1, 0,   1, 0, 0, 1);
        add("run4_sync",   1, 1, 0,   2, 0, 0, 1);
`else
        add("fs_evt",      1, 1, 0,   1, 1, 0, 0);
        add("fs_hold",     1, 1, 0,  30, 1, 0, 0);
        add("run4_lo",     0, 1, 0,   1, 1, 0, 0);
        add("run4_sync",   1, 1, 0,   2, 1, 0, 0);
`endif
        add("run4",        1, 1, 0,   1, 1, 0, 0);
        add("both_lo",     1, 0, 0,   1, 1, 0, 0);
        add("both_sync",   1, 1, 0,   2, 1, 0, 0);
        add("both_evt",    1, 1, 1,   1, 2, 0, 0);
        add("both_after",  1, 1, 0,  20, 2, 0, 0);
        add("end_lo",      1, 0, 0,   1, 2, 0, 0);
        add("end_sync",    1, 1, 0,   2, 2, 0, 0);
        add("end_disp",    1, 1, 0,   1, 3, 0, 0);
        add("b_wait",      1, 1, 0, 600, 3, 0, 0);
        add("bounce0",     0, 1, 0,   1, 3, 0, 0);
        add("bounce1",     1, 1, 0,   1, 3, 0, 0);
        add("bounce2",     0, 1, 0,   1, 3, 0, 0);
        add("bounce_idle", 1, 1, 0,   1, 0, 0, 0);
        add("bounce4",     0, 1, 0,   2, 0, 0, 0);
        add("bounce_one",  1, 1, 0,  30, 0, 0, 0);
        add("ss_lo",       0, 0, 0,   1, 0, 0, 0);
        add("ss_sync",     1, 1, 0,   2, 0, 0, 0);
        add("ss_delay",    1, 1, 0,   1, 1, 0, 0);
        add("ss_after",    1, 1, 0,  10, 1, 0, 0);

        Reset = 1'b1; bus.StartN = 1'b1; bus.StopN = 1'b1; bus.Flag = 1'b0;
        tick(); tick();
        check("reset_init", ex(0, 0, 0));
        Reset = 1'b0;

        foreach (tbl[i]) begin
            bus.StartN = tbl[i].start_n;
            bus.StopN  = tbl[i].stop_n;
            bus.Flag   = tbl[i].flag;
            repeat (tbl[i].cyc) tick();
            check(tbl[i].name, tbl[i].exp);
        end
        bus.StartN = 1'b1; bus.StopN = 1'b1; bus.Flag = 1'b0;

        // Stop landing exactly 200 cycles into TIMING
        do_reset("A_reset");
        press_key(0); tick();
        check("A_delay", ex(1, 0, 0));
        bus.Flag = 1'b1; tick(); bus.Flag = 1'b0;
        check("A_timing", ex(2, 0, 0));
        count_timing(197, n2);
        check_int("A_timing_len", n2, 200);
        check("A_display", ex(3, 0, 0));

        // No Stop: forced end after exactly TIMEOUT_MS cycles
        do_reset("B_reset");
        press_key(0); tick();
        bus.Flag = 1'b1; tick(); bus.Flag = 1'b0;
        count_timing(-1, n2);
        check_int("B_timing_len", n2, TIMEOUT_MS);
        check("B_timeout", ex(3, 1, 0));

        // Reset clears a latched Timeout, then reset mid-TIMING
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("C_reset_disp", ex(0, 0, 0));
        press_key(0); tick();
        bus.Flag = 1'b1; tick(); bus.Flag = 1'b0;
        repeat (50) tick();
        check("C_timing", ex(2, 0, 0));
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("C_reset_timing", ex(0, 0, 0));
        press_key(0); tick();
        check("C_delay", ex(1, 0, 0));
        press_key(1);
        bus.Flag = 1'b1; tick(); bus.Flag = 1'b0;
        check("C_flag_wins", ex(2, 0, 0));
        repeat (40) tick();
        check("C_stop_consumed", ex(2, 0, 0));

        // Randomized traffic against the reference model
        do_reset("R_reset");
        for (int c = 0; c < 25000; c++) begin
            for (int k = 0; k < 2; k++)
                if (lo_left[k] == 0 && $urandom_range(0, rate[k]) == 0)
                    lo_left[k] = int'($urandom_range(1, 40));
            bus.StartN = (lo_left[0] == 0);
            bus.StopN  = (lo_left[1] == 0);
            for (int k = 0; k < 2; k++)
                if (lo_left[k] > 0) lo_left[k]--;
            bus.Flag = ($urandom_range(0, 39) == 0);
            Reset    = ($urandom_range(0, 3999) == 0);
            tick();
            check($sformatf("rand_%0d", c), model_exp());
        end
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
